// File: rtl/scandbl_pkg.sv
// Shared types and constants for the 15 kHz -> 31 kHz VGA scandoubler.
// Optional feature macro: SCANDOUBLER_SCANLINES_EN (half-intensity second pass).
package scandbl_pkg;

  typedef struct packed {
    logic [2:0] r;
    logic [2:0] g;
    logic [2:0] b;
  } rgb9_t;

  // Phase of the free-running 2-bit counter on which a 7 MHz sample is taken.
  localparam logic [1:0] PH_WR = 2'd3;

  localparam int HS_WIDTH_DEF  = 54;
  localparam int VS_THRESH_DEF = 128;

  function automatic rgb9_t half_rgb(input rgb9_t c);
    half_rgb = '{r: c.r >> 1, g: c.g >> 1, b: c.b >> 1};
  endfunction

endpackage

// File: rtl/scandbl_linebuf.sv
// Ping-pong line buffer: simple dual-port RAM, one write port and one
// registered read port on a single clock, so it maps onto block RAM.
module scandbl_linebuf
  import scandbl_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  rgb9_t             wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output rgb9_t             rdata
);

  rgb9_t mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/vga_scandoubler.sv
// Scandoubler top: captures each 15 kHz line at 7 MHz and replays the previous
// one twice at 14 MHz. Macro SCANDOUBLER_SCANLINES_EN dims the second pass.
module vga_scandoubler
  import scandbl_pkg::*;
#(
  parameter int HS_WIDTH  = HS_WIDTH_DEF,
  parameter int VS_THRESH = VS_THRESH_DEF,
  parameter int ADDR_W    = 9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] ri,
  input  logic [2:0] gi,
  input  logic [2:0] bi,
  input  logic       csync_i,
  input  logic       enable,
  output logic [2:0] ro,
  output logic [2:0] go,
  output logic [2:0] bo,
  output logic       hsync_n,
  output logic       vsync_n
);

  localparam int LC_W = $clog2(VS_THRESH + 1);
  localparam logic [ADDR_W-1:0] PTR_MAX = '1;

  rgb9_t             in_reg;
  logic              csync_reg;
  logic [1:0]        ph_reg;
  logic              wr_en;
  logic              rd_en;
  logic              line_start;

  logic              csync_prev_reg;
  logic              line_seen_reg;
  logic              wbank_reg;
  logic [ADDR_W-1:0] wptr_reg;
  logic [ADDR_W-1:0] len_reg;
  logic [ADDR_W-1:0] len_next;

  logic [ADDR_W-1:0] rptr_reg;
  logic              pass_reg;
  logic              active_reg;
  logic              vis_reg;
  logic              hs_reg;
  logic              dbl_ok_reg;

  logic [LC_W-1:0]   lowcnt_reg;
  logic [LC_W-1:0]   lowcnt_inc;
  logic              vs_reg;

  logic [ADDR_W:0]   waddr;
  logic [ADDR_W:0]   raddr;
  rgb9_t             rd_q;
  rgb9_t             pix;

  always_ff @(posedge clk) begin
    if (rst) begin
      in_reg    <= '0;
      csync_reg <= 1'b1;
      ph_reg    <= '0;
    end else begin
      in_reg    <= '{r: ri, g: gi, b: bi};
      csync_reg <= csync_i;
      ph_reg    <= ph_reg + 2'd1;
    end
  end

  assign wr_en      = (ph_reg == PH_WR);
  assign rd_en      = ph_reg[0];
  assign line_start = wr_en && csync_prev_reg && !csync_reg;

  // The first line start after reset closes a partial line, so it replays nothing.
  assign len_next = line_seen_reg ? wptr_reg : '0;

  // wptr holds the index of the next sample; the line-start sample itself is
  // entry 0 of the freshly toggled bank, so an N-sample line gives len = N.
  always_ff @(posedge clk) begin
    if (rst) begin
      csync_prev_reg <= 1'b0;
      line_seen_reg  <= 1'b0;
      wbank_reg      <= 1'b0;
      wptr_reg       <= '0;
      len_reg        <= '0;
    end else if (wr_en) begin
      csync_prev_reg <= csync_reg;
      if (line_start) begin
        len_reg       <= len_next;
        line_seen_reg <= 1'b1;
        wbank_reg     <= !wbank_reg;
        wptr_reg      <= ADDR_W'(1);
      end else if (wptr_reg != PTR_MAX) begin
        wptr_reg <= wptr_reg + ADDR_W'(1);
      end
    end
  end

  assign waddr = line_start ? {!wbank_reg, ADDR_W'(0)} : {wbank_reg, wptr_reg};
  assign raddr = {!wbank_reg, rptr_reg};

  scandbl_linebuf #(
    .ADDR_W(ADDR_W + 1)
  ) u_linebuf (
    .clk  (clk),
    .we   (wr_en),
    .waddr(waddr),
    .wdata(in_reg),
    .re   (rd_en),
    .raddr(raddr),
    .rdata(rd_q)
  );

  // Slot flags are captured alongside the RAM read so they line up with rd_q.
  always_ff @(posedge clk) begin
    if (rst) begin
      rptr_reg   <= '0;
      pass_reg   <= 1'b0;
      active_reg <= 1'b0;
      vis_reg    <= 1'b0;
      hs_reg     <= 1'b1;
    end else if (rd_en) begin
      vis_reg <= active_reg;
      hs_reg  <= !(active_reg && (int'(rptr_reg) < HS_WIDTH));
      if (line_start) begin
        rptr_reg   <= '0;
        pass_reg   <= 1'b0;
        active_reg <= (len_next != '0);
      end else if (active_reg) begin
        if (rptr_reg == len_reg - ADDR_W'(1)) begin
          rptr_reg <= '0;
          pass_reg <= 1'b1;
          if (pass_reg) active_reg <= 1'b0;
        end else begin
          rptr_reg <= rptr_reg + ADDR_W'(1);
        end
      end
    end
  end

  // After a spell in bypass, doubled output stays dark until a fresh line start.
  always_ff @(posedge clk) begin
    if (rst)             dbl_ok_reg <= 1'b1;
    else if (!enable)    dbl_ok_reg <= 1'b0;
    else if (line_start) dbl_ok_reg <= 1'b1;
  end

  assign lowcnt_inc = (lowcnt_reg == '1) ? lowcnt_reg : lowcnt_reg + LC_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      lowcnt_reg <= '0;
      vs_reg     <= 1'b0;
    end else if (wr_en) begin
      if (csync_reg) begin
        lowcnt_reg <= '0;
        vs_reg     <= 1'b0;
      end else begin
        lowcnt_reg <= lowcnt_inc;
        vs_reg     <= (int'(lowcnt_inc) >= VS_THRESH);
      end
    end
  end

`ifdef SCANDOUBLER_SCANLINES_EN
  logic pass_d_reg;

  always_ff @(posedge clk) begin
    if (rst)        pass_d_reg <= 1'b0;
    else if (rd_en) pass_d_reg <= pass_reg;
  end

  assign pix = pass_d_reg ? half_rgb(rd_q) : rd_q;
`else
  assign pix = rd_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      ro      <= '0;
      go      <= '0;
      bo      <= '0;
      hsync_n <= 1'b1;
      vsync_n <= 1'b1;
    end else if (!enable) begin
      ro      <= in_reg.r;
      go      <= in_reg.g;
      bo      <= in_reg.b;
      hsync_n <= csync_reg;
      vsync_n <= 1'b1;
    end else begin
      if (dbl_ok_reg && vis_reg) begin
        ro <= pix.r;
        go <= pix.g;
        bo <= pix.b;
      end else begin
        ro <= '0;
        go <= '0;
        bo <= '0;
      end
      hsync_n <= dbl_ok_reg ? hs_reg : 1'b1;
      vsync_n <= !vs_reg;
    end
  end

endmodule

// File: tb/tb_vga_scandoubler.sv
// Self-checking bench for vga_scandoubler: directed line sequence with random
// colours, compared every clock against a line-level model of the replay.
module tb_vga_scandoubler;

  localparam int HS  = 54;
  localparam int VST = 128;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] ri = '0, gi = '0, bi = '0;
  logic       csync_i = 1'b1;
  logic       enable = 1'b1;
  logic [2:0] ro, go, bo;
  logic       hsync_n, vsync_n;

  always #5 clk = ~clk;

  vga_scandoubler #(
    .HS_WIDTH (HS),
    .VS_THRESH(VST),
    .ADDR_W   (9)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .ri     (ri),
    .gi     (gi),
    .bi     (bi),
    .csync_i(csync_i),
    .enable (enable),
    .ro     (ro),
    .go     (go),
    .bo     (bo),
    .hsync_n(hsync_n),
    .vsync_n(vsync_n)
  );

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int line_no  = 0;

  // Line-level model: samples since the last line start, plus the two most
  // recently completed lines and the clock on which each was closed.
  logic [8:0] acc[$];
  logic [8:0] cur_d[$];
  logic [8:0] prv_d[$];
  int   cur_len = 0, prv_len = 0;
  int   e_cur = -1, e_prv = -1;
  bit   seen = 1'b0;
  bit   cs_last = 1'b0;
  int   low_run = 0;
  bit   vs_m = 1'b0;
  bit   dbl_m = 1'b1;
  logic [8:0] pv_col = '0;
  logic       pv_cs = 1'b1;

  task automatic tick();
    logic [8:0] at_col, px, col_e, col_o;
    logic at_cs, at_en, hs_e, vs_e, ls, valid;
    int s, ln, j, k;
    at_col = {ri, gi, bi};
    at_cs  = csync_i;
    at_en  = enable;
    @(posedge clk);
    cyc++;
    px = '0; valid = 1'b0; ln = 0; j = 0; k = 0; ls = 1'b0;
    if (!at_en) begin
      col_e = pv_col;
      hs_e  = pv_cs;
      vs_e  = 1'b1;
    end else begin
      // latest 14 MHz read slot whose pixel is now on the output
      s = (cyc % 2 == 1) ? cyc - 1 : cyc - 2;
      if (e_cur >= 0 && s > e_cur) begin
        ln = cur_len;
        j  = (s - e_cur - 2) / 2;
        if (ln > 0 && j < 2 * ln) begin k = j % ln; px = cur_d[k]; valid = 1'b1; end
      end else if (e_prv >= 0 && s > e_prv) begin
        ln = prv_len;
        j  = (s - e_prv - 2) / 2;
        if (ln > 0 && j < 2 * ln) begin k = j % ln; px = prv_d[k]; valid = 1'b1; end
      end
      valid = valid && dbl_m;
`ifdef SCANDOUBLER_SCANLINES_EN
      if (j >= ln) px = {1'b0, px[8:7], 1'b0, px[5:4], 1'b0, px[2:1]};
`endif
      col_e = valid ? px : 9'd0;
      hs_e  = !(valid && k < HS);
      vs_e  = !vs_m;
    end
    if (cyc % 4 == 0) begin
      ls = cs_last && !pv_cs;
      cs_last = pv_cs;
      if (ls) begin
        prv_d = cur_d; prv_len = cur_len; e_prv = e_cur;
        cur_len = !seen ? 0 : (acc.size() > 511 ? 511 : acc.size());
        cur_d = acc; e_cur = cyc; seen = 1'b1;
        $display("line %0d: start at cycle %0d, captured %0d samples, replay len %0d",
                 line_no, cyc, acc.size(), cur_len);
        line_no++;
        acc = {};
      end
      acc.push_back(pv_col);
      if (pv_cs) begin
        low_run = 0; vs_m = 1'b0;
      end else begin
        low_run++; vs_m = (low_run >= VST);
      end
    end
    if (!at_en) dbl_m = 1'b0;
    else if (ls) dbl_m = 1'b1;
    pv_col = at_col;
    pv_cs  = at_cs;
    @(negedge clk);
    col_o = {ro, go, bo};
    n_assert++;
    assert (col_o === col_e) else begin
      n_fail++;
      $error("FAIL colour cyc=%0d got %o want %o", cyc, col_o, col_e);
    end
    n_assert++;
    assert (hsync_n === hs_e) else begin
      n_fail++;
      $error("FAIL hsync_n cyc=%0d got %b want %b", cyc, hsync_n, hs_e);
    end
    n_assert++;
    assert (vsync_n === vs_e) else begin
      n_fail++;
      $error("FAIL vsync_n cyc=%0d got %b want %b", cyc, vsync_n, vs_e);
    end
  endtask

  // mode: 0 ramp (index mod 512), 1 random, 2 constant 5/2/6, 3 constant 7/7/7
  task automatic drive_line(input int n, input int lo, input int mode,
                            input int tog_off, input int tog_on);
    logic [8:0] col;
    for (int i = 0; i < n; i++) begin
      case (mode)
        0:       col = 9'(i);
        1:       col = 9'($urandom);
        2:       col = 9'o526;
        default: col = 9'o777;
      endcase
      {ri, gi, bi} = col;
      csync_i = (i < lo) ? 1'b0 : 1'b1;
      if (i == tog_off) enable = 1'b0;
      if (i == tog_on)  enable = 1'b1;
      repeat (4) tick();
    end
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_assert++;
    assert ({ro, go, bo} === 9'd0) else begin
      n_fail++; $error("FAIL reset_colour got %o want 0", {ro, go, bo});
    end
    n_assert++;
    assert (hsync_n === 1'b1) else begin
      n_fail++; $error("FAIL reset_hsync got %b want 1", hsync_n);
    end
    n_assert++;
    assert (vsync_n === 1'b1) else begin
      n_fail++; $error("FAIL reset_vsync got %b want 1", vsync_n);
    end
    rst = 1'b0;
    cyc = 0;

    drive_line(10, 0, 1, -1, -1);       // idle, csync high
    drive_line(448, 32, 0, -1, -1);     // first line after reset: replays nothing
    drive_line(448, 32, 0, -1, -1);     // replays the ramp twice
    drive_line(448, 32, 1, -1, -1);     // replays the second ramp
    drive_line(456, 32, 2, 100, 300);   // bypass toggle mid-line
    drive_line(600, 32, 1, -1, -1);     // overlong line
    drive_line(600, 32, 3, -1, -1);     // replays overlong line: 511 slots per pass, then black
    drive_line(448, 32, 1, -1, -1);     // replays 7/7/7 line
    drive_line(448, 200, 1, -1, -1);    // long csync low: vertical sync
    drive_line(448, 100, 0, -1, -1);    // short csync low: no vertical sync
    drive_line(448, 32, 0, -1, -1);
    drive_line(100, 32, 1, -1, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
